ldst_sequencer: RTL and testbench

Hardwired control-step sequencer for the Mini-SRC datapath that drives the fetch, ld, ldi and st control steps. The datapath testbenches currently drive these steps by hand. The block sits beside `datapath` and produces the same control strobes. It has a parametrised memory wait-state count, back-to-back instruction issue, and illegal-opcode detection. Optional store support is described under Configuration.

---
 rtl/ldst_sequencer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_ldst_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ldst_sequencer.sv
// Hardwired fetch/ld/ldi/st control-step sequencer for the Mini-SRC datapath.
// Define LDST_STORE_EN to compile in the st path (T6 register read, T7 Write).
module ldst_sequencer #(
  parameter int OP_W = 5,
  parameter logic [OP_W-1:0] ADD_CODE = OP_W'(5'b00100),
  parameter int MEM_WAIT = 0,
  parameter int CNT_W = 4
) (
  input  logic            Clock,
  input  logic            Clear,
  input  logic            Run,
  input  logic [OP_W-1:0] IR_op,
  output logic            PCout,
  output logic            MARin,
  output logic            IncPC,
  output logic            Read,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Grb,
  output logic            BAout,
  output logic            Yin,
  output logic            Cout,
  output logic            ZHighin,
  output logic            ZLowin,
  output logic            ZLowout,
  output logic            Gra,
  output logic            Rin,
  output logic            Rout,
  output logic            Write,
  output logic [OP_W-1:0] OP,
  output logic [3:0]      T_state,
  output logic            Busy,
  output logic            Done,
  output logic            Illegal
);

  typedef enum logic [3:0] {
    IDLE = 4'd0, T0 = 4'd1, T1 = 4'd2,
    T2 = 4'd3, T3 = 4'd4, T4 = 4'd5,
    T5 = 4'd6, T6 = 4'd7, T7 = 4'd8,
    DONE = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    C_LD, C_LDI, C_ST, C_ILL
  } cls_t;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic grb;
    logic ba_out;
    logic y_in;
    logic c_out;
    logic zhigh_in;
    logic zlow_in;
    logic zlow_out;
    logic gra;
    logic r_in;
  } ctl_t;

  localparam logic [CNT_W-1:0] WAIT = CNT_W'(MEM_WAIT);

  state_t           state_q, state_d;
  cls_t             cls_q, cls_d, op_cls;
  logic             ill_q, ill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctl_t             ctl_q, ctl_d;
  logic [OP_W-1:0]  op_q, op_d;

  // Opcode classification; st only exists when the store path is built
  always_comb begin
    op_cls = C_ILL;
    if (IR_op == OP_W'(0)) op_cls = C_LD;
    else if (IR_op == OP_W'(1)) op_cls = C_LDI;
`ifdef LDST_STORE_EN
    else if (IR_op == OP_W'(2)) op_cls = C_ST;
`endif
  end

  // Step sequencing, class latch and memory wait counter
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (Run) state_d = T0;
      T0: begin
        state_d = T1;
        cnt_d   = WAIT;
      end
      T1: begin
        if (cnt_q == '0) state_d = T2;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      T2: state_d = T3;
      T3: begin
        cls_d   = op_cls;
        ill_d   = (op_cls == C_ILL);
        state_d = (op_cls == C_ILL) ? DONE : T4;
      end
      T4: state_d = T5;
      T5: begin
        if (cls_q == C_LDI) begin
          state_d = DONE;
        end else begin
          state_d = T6;
          if (cls_q == C_LD) cnt_d = WAIT;
        end
      end
      T6: begin
        if (cls_q == C_LD) begin
          if (cnt_q == '0) state_d = T7;
          else cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = T7;
          cnt_d   = WAIT;
        end
      end
      T7: begin
        if (cls_q == C_LD || cnt_q == '0) state_d = DONE;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      DONE: begin
        ill_d   = 1'b0;
        state_d = Run ? T0 : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef LDST_STORE_EN
  logic rout_q, rout_d;
  logic write_q, write_d;
`endif

  // Strobes for the step being entered, so they leave flops cleanly
  always_comb begin
    ctl_d = '0;
    op_d  = '0;
`ifdef LDST_STORE_EN
    rout_d  = 1'b0;
    write_d = 1'b0;
`endif
    case (state_d)
      T0: begin
        ctl_d.pc_out = 1'b1;
        ctl_d.mar_in = 1'b1;
        ctl_d.inc_pc = 1'b1;
      end
      T1: begin
        ctl_d.read   = 1'b1;
        ctl_d.mdr_in = 1'b1;
      end
      T2: begin
        ctl_d.mdr_out = 1'b1;
        ctl_d.ir_in   = 1'b1;
      end
      T3: begin
        ctl_d.grb    = 1'b1;
        ctl_d.ba_out = 1'b1;
        ctl_d.y_in   = 1'b1;
      end
      T4: begin
        ctl_d.c_out    = 1'b1;
        ctl_d.zhigh_in = 1'b1;
        ctl_d.zlow_in  = 1'b1;
        op_d           = ADD_CODE;
      end
      T5: begin
        ctl_d.zlow_out = 1'b1;
        if (cls_d == C_LDI) begin
          ctl_d.gra  = 1'b1;
          ctl_d.r_in = 1'b1;
        end else begin
          ctl_d.mar_in = 1'b1;
        end
      end
      T6: begin
        if (cls_d == C_LD) begin
          ctl_d.read   = 1'b1;
          ctl_d.mdr_in = 1'b1;
        end
`ifdef LDST_STORE_EN
        else if (cls_d == C_ST) begin
          ctl_d.gra    = 1'b1;
          ctl_d.mdr_in = 1'b1;
          rout_d       = 1'b1;
        end
`endif
      end
      T7: begin
        if (cls_d == C_LD) begin
          ctl_d.mdr_out = 1'b1;
          ctl_d.gra     = 1'b1;
          ctl_d.r_in    = 1'b1;
        end
`ifdef LDST_STORE_EN
        else if (cls_d == C_ST) begin
          write_d = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  // State, class, counter and registered strobes
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_q <= IDLE;
      cls_q   <= C_LD;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
      ctl_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
      op_q    <= op_d;
    end
  end

`ifdef LDST_STORE_EN
  // Store-only strobes
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      rout_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      rout_q  <= rout_d;
      write_q <= write_d;
    end
  end
  assign Rout  = rout_q;
  assign Write = write_q;
`else
  assign Rout  = 1'b0;
  assign Write = 1'b0;
`endif

  assign {PCout, MARin, IncPC, Read,
          MDRin, MDRout, IRin, Grb,
          BAout, Yin, Cout, ZHighin,
          ZLowin, ZLowout, Gra, Rin} = ctl_q;

  assign OP      = op_q;
  assign T_state = state_q;
  assign Busy    = (state_q != IDLE);
  assign Done    = (state_q == DONE);
  assign Illegal = (state_q == DONE) & ill_q;

endmodule

// File: tb/tb_ldst_sequencer.sv
// Directed bench for ldst_sequencer: three copies with MEM_WAIT = 0, 2, 3.
// Expected step sequences and counts are worked out by hand per instruction.
module tb_ldst_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr [3];
  logic       run [3];
  logic [4:0] irop [3];

  logic pcout [3], marin [3], incpc [3];
  logic read [3], mdrin [3], mdrout [3];
  logic irin [3], grb [3], baout [3];
  logic yin [3], cout [3], zhighin [3];
  logic zlowin [3], zlowout [3], gra [3];
  logic rin [3], rout [3], write [3];
  logic busy [3], done [3], ill [3];
  logic [4:0] opo [3];
  logic [3:0] ts [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
    ldst_sequencer #(.MEM_WAIT(W)) u_dut (
      .Clock(clk), .Clear(clr[g]),
      .Run(run[g]), .IR_op(irop[g]),
      .PCout(pcout[g]), .MARin(marin[g]),
      .IncPC(incpc[g]), .Read(read[g]),
      .MDRin(mdrin[g]), .MDRout(mdrout[g]),
      .IRin(irin[g]), .Grb(grb[g]),
      .BAout(baout[g]), .Yin(yin[g]),
      .Cout(cout[g]), .ZHighin(zhighin[g]),
      .ZLowin(zlowin[g]), .ZLowout(zlowout[g]),
      .Gra(gra[g]), .Rin(rin[g]),
      .Rout(rout[g]), .Write(write[g]),
      .OP(opo[g]), .T_state(ts[g]),
      .Busy(busy[g]), .Done(done[g]),
      .Illegal(ill[g])
    );
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
    end
  endtask

  function automatic int any_out(input int g);
    logic a;
    a = pcout[g] | marin[g] | incpc[g] | read[g] |
        mdrin[g] | mdrout[g] | irin[g] | grb[g] |
        baout[g] | yin[g] | cout[g] | zhighin[g] |
        zlowin[g] | zlowout[g] | gra[g] | rin[g] |
        rout[g] | write[g] | busy[g] | done[g] |
        ill[g] | (|opo[g]) | (|ts[g]);
    return int'(a);
  endfunction

  logic [3:0] tseq [64];
  int len, ndone, nill, rd, rd1, wr, wr7;
  int op_bad, t7_hit, t7_other, t4_any;
  int t5_ldi, t6_st, busy_drop, idle_ok;

  // Issue one instruction (or a Run burst) and gather per-step statistics
  task automatic trace(input int g, input logic [4:0] op,
                       input int hold, input bit scr);
    len = 0; ndone = 0; nill = 0; rd = 0;
    rd1 = 0; wr = 0; wr7 = 0; op_bad = 0;
    t7_hit = 0; t7_other = 0; t4_any = 0;
    t5_ldi = 0; t6_st = 0; busy_drop = 0;
    idle_ok = 0;
    foreach (tseq[i]) tseq[i] = 4'hf;
    run[g] = 1'b1;
    irop[g] = op;
    for (int i = 0; i < 63; i++) begin
      @(negedge clk);
      tseq[i] = ts[g];
      if (i + 1 >= hold) run[g] = 1'b0;
      if (ts[g] == 4'd0) begin
        idle_ok = 1;
        break;
      end
      len++;
      if (!busy[g]) busy_drop++;
      if (done[g]) ndone++;
      if (ill[g]) nill++;
      if (read[g]) begin
        rd++;
        if (ts[g] == 4'd2) rd1++;
      end
      if (write[g]) begin
        wr++;
        if (ts[g] == 4'd8) wr7++;
      end
      if (ts[g] == 4'd5) begin
        if (opo[g] != 5'b00100) op_bad++;
      end else if (opo[g] != 5'd0) op_bad++;
      if (gra[g] & rin[g] & mdrout[g]) begin
        if (ts[g] == 4'd8) t7_hit++;
        else t7_other++;
      end
      if (cout[g] | zhighin[g] | zlowin[g]) t4_any++;
      if (ts[g] == 4'd6 && zlowout[g] &&
          gra[g] && rin[g] && !marin[g]) t5_ldi++;
      if (ts[g] == 4'd7 && rout[g] &&
          mdrin[g] && !read[g]) t6_st++;
      if (scr && ts[g] == 4'd5) irop[g] = 5'b11111;
    end
    run[g] = 1'b0;
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      clr[g] = 1'b1;
      run[g] = 1'b0;
      irop[g] = 5'd0;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("rst_ts", ts[g], 0);
      chk("rst_out", any_out(g), 0);
      clr[g] = 1'b0;
    end
    @(negedge clk);

    // ld, W=0, IR_op scrambled after T3
    trace(0, 5'd0, 1, 1'b1);
    chk("ld_end", idle_ok, 1);
    for (int i = 0; i < 10; i++)
      chk("ld_seq", tseq[i], (i < 9) ? i + 1 : 0);
    chk("ld_len", len, 9);
    chk("ld_done", ndone, 1);
    chk("ld_ill", nill, 0);
    chk("ld_op", op_bad, 0);
    chk("ld_t7", t7_hit, 1);
    chk("ld_t7x", t7_other, 0);
    chk("ld_rd", rd, 2);

    // ldi, W=0
    trace(0, 5'd1, 1, 1'b0);
    chk("ldi_end", idle_ok, 1);
    chk("ldi_len", len, 7);
    chk("ldi_done_at", tseq[6], 9);
    chk("ldi_t5", t5_ldi, 1);
    chk("ldi_done", ndone, 1);
    chk("ldi_ill", nill, 0);

    // illegal opcode, W=0
    trace(0, 5'b11111, 1, 1'b0);
    chk("il_end", idle_ok, 1);
    chk("il_len", len, 5);
    chk("il_done_at", tseq[4], 9);
    chk("il_ill", nill, 1);
    chk("il_done", ndone, 1);
    chk("il_t4", t4_any, 0);

    // two ld back to back with Run held
    trace(0, 5'd0, 10, 1'b0);
    chk("b2b_end", idle_ok, 1);
    chk("b2b_len", len, 18);
    chk("b2b_t0", tseq[9], 1);
    chk("b2b_done", ndone, 2);
    chk("b2b_busy", busy_drop, 0);

    // st, W=2
    trace(1, 5'd2, 1, 1'b0);
    chk("st_end", idle_ok, 1);
`ifdef LDST_STORE_EN
    chk("st_len", len, 13);
    chk("st_rd1", rd1, 3);
    chk("st_rd", rd, 3);
    chk("st_wr7", wr7, 3);
    chk("st_wr", wr, 3);
    chk("st_t6", t6_st, 1);
    chk("st_ill", nill, 0);
`else
    chk("st_len", len, 7);
    chk("st_done_at", tseq[6], 9);
    chk("st_ill", nill, 1);
    chk("st_wr", wr, 0);
`endif

    // ld, W=2
    trace(1, 5'd0, 1, 1'b0);
    chk("ld2_end", idle_ok, 1);
    chk("ld2_len", len, 13);
    chk("ld2_rd", rd, 6);
    chk("ld2_rd1", rd1, 3);

    // Clear in the middle of T4, W=3
    run[2] = 1'b1;
    irop[2] = 5'd0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      run[2] = 1'b0;
      if (ts[2] == 4'd5) break;
    end
    chk("clr_t4", ts[2], 5);
    #2 clr[2] = 1'b1;
    #1;
    chk("clr_ts", ts[2], 0);
    chk("clr_out", any_out(2), 0);
    @(negedge clk);
    chk("clr_hold", any_out(2), 0);
    clr[2] = 1'b0;
    trace(2, 5'd0, 1, 1'b0);
    chk("clr_end", idle_ok, 1);
    chk("clr_len", len, 15);
    chk("clr_rd", rd, 8);
    chk("clr_t1", tseq[4], 2);
    chk("clr_t2", tseq[5], 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
